// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle for one data-RAM requester.
// Ports: req/we/addr/wdata/be toward arbiter; gnt/rvalid/rdata back.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the data RAM between core (C) and debug (D).
// Ports: clk_i, reset_ni (sync, active-low), c_if/d_if requester
// bundles, ram_* RAM command side, ram_rdata_i read return.
// Define RAM_ARB_LOCK_EN to add d_lock_i and the OPEN/LOCKED FSM.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
`ifdef RAM_ARB_LOCK_EN
  input  logic                  d_lock_i,
`endif
  ram_port_arbiter_if.slave     c_if,
  ram_port_arbiter_if.slave     d_if,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [3:0]            ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic rr_q;
  logic c_ok;
  logic c_win, d_win;
  logic c_gnt, d_gnt;
  logic locked, lock_exit;

  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_d;
  logic c_rv, d_rv;
  logic [DATA_WIDTH-1:0] c_hold, d_hold;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic {OPEN, LOCKED} lock_e;
  lock_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= OPEN;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OPEN:   if (d_gnt && d_lock_i) state_d = LOCKED;
      LOCKED: if (!d_lock_i)         state_d = OPEN;
    endcase
  end

  // C stays blocked through the cycle that drops the lock.
  assign locked    = (state_q == LOCKED);
  assign lock_exit = locked & ~d_lock_i;
`else
  assign locked    = 1'b0;
  assign lock_exit = 1'b0;
`endif

  assign c_ok  = ~locked;
  assign c_win = c_if.req & c_ok &
                 (~d_if.req | (rr_q == PORT_C));
  assign d_win = d_if.req & ~c_win;

  // Reset masks grants combinationally.
  assign c_gnt = reset_ni & c_win;
  assign d_gnt = reset_ni & d_win;

  assign c_if.gnt = c_gnt;
  assign d_if.gnt = d_gnt;

  assign ram_en_o    = c_gnt | d_gnt;
  assign ram_we_o    = d_gnt ? d_if.we : (c_gnt & c_if.we);
  assign ram_addr_o  = d_gnt ? d_if.addr  : c_if.addr;
  assign ram_wdata_o = d_gnt ? d_if.wdata : c_if.wdata;
  assign ram_be_o    = d_gnt ? d_if.be    : c_if.be;

  always_ff @(posedge clk_i) begin
    if (!reset_ni)
      rr_q <= PORT_C;
    else if (lock_exit)
      rr_q <= PORT_C;
    else if (!locked && ram_en_o)
      rr_q <= d_gnt ? PORT_C : PORT_D;
  end

  // tag_v/tag_d: valid and owner (1 = D) of each read in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v[0] <= ram_en_o & ~ram_we_o;
      tag_d[0] <= d_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_d[i] <= tag_d[i-1];
      end
    end
  end

  assign c_rv = tag_v[RD_LATENCY-1] & ~tag_d[RD_LATENCY-1];
  assign d_rv = tag_v[RD_LATENCY-1] &  tag_d[RD_LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      c_hold <= '0;
      d_hold <= '0;
    end else begin
      if (c_rv) c_hold <= ram_rdata_i;
      if (d_rv) d_hold <= ram_rdata_i;
    end
  end

  assign c_if.rvalid = c_rv;
  assign d_if.rvalid = d_rv;
  assign c_if.rdata  = c_rv ? ram_rdata_i : c_hold;
  assign d_if.rdata  = d_rv ? ram_rdata_i : d_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at read latency 1,
// one at latency 3, each with a small behavioural RAM.
module tb_ram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int n_vec = 0;
  int n_err = 0;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c1 ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) d1 ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c3 ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) d3 ();

  logic          en1, we1, en3, we3;
  logic [AW-1:0] a1, a3;
  logic [DW-1:0] wd1, rd1, wd3, rd3;
  logic [3:0]    be1, be3;
`ifdef RAM_ARB_LOCK_EN
  logic lock1;
`endif

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)
  ) u1 (
    .clk_i(clk), .reset_ni(rst_n),
`ifdef RAM_ARB_LOCK_EN
    .d_lock_i(lock1),
`endif
    .c_if(c1), .d_if(d1),
    .ram_en_o(en1), .ram_we_o(we1), .ram_addr_o(a1),
    .ram_wdata_o(wd1), .ram_be_o(be1), .ram_rdata_i(rd1)
  );

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)
  ) u3 (
    .clk_i(clk), .reset_ni(rst_n),
`ifdef RAM_ARB_LOCK_EN
    .d_lock_i(1'b0),
`endif
    .c_if(c3), .d_if(d3),
    .ram_en_o(en3), .ram_we_o(we3), .ram_addr_o(a3),
    .ram_wdata_o(wd3), .ram_be_o(be3), .ram_rdata_i(rd3)
  );

  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] p3 [3];

  always @(posedge clk) begin
    if (en1 && we1)
      for (int b = 0; b < 4; b++)
        if (be1[b]) mem1[a1][b*8 +: 8] <= wd1[b*8 +: 8];
    rd1 <= (en1 && !we1) ? mem1[a1] : '0;
  end

  always @(posedge clk) begin
    if (en3 && we3)
      for (int b = 0; b < 4; b++)
        if (be3[b]) mem3[a3][b*8 +: 8] <= wd3[b*8 +: 8];
    p3[0] <= (en3 && !we3) ? mem3[a3] : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd3 = p3[2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp3 [3];
  int cg, dg;

  initial begin
    exp3[0] = 32'hA1A1_A1A1;
    exp3[1] = 32'hB2B2_B2B2;
    exp3[2] = 32'hC3C3_C3C3;
    c1.req = 1'b0; c1.we = 1'b0; c1.addr = '0; c1.wdata = '0; c1.be = 4'hF;
    d1.req = 1'b0; d1.we = 1'b0; d1.addr = '0; d1.wdata = '0; d1.be = 4'hF;
    c3.req = 1'b0; c3.we = 1'b0; c3.addr = '0; c3.wdata = '0; c3.be = 4'hF;
    d3.req = 1'b0; d3.we = 1'b0; d3.addr = '0; d3.wdata = '0; d3.be = 4'hF;
`ifdef RAM_ARB_LOCK_EN
    lock1 = 1'b0;
`endif

    // reset with both ports requesting writes
    rst_n = 1'b0;
    c1.req = 1'b1; c1.we = 1'b1; c1.addr = 10'h3F0;
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 10'h3F1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_c_gnt", c1.gnt, 0);
    chk("rst_d_gnt", d1.gnt, 0);
    chk("rst_ram_en", en1, 0);
    chk("rst_c_rv", c1.rvalid, 0);
    chk("rst_d_rv", d1.rvalid, 0);
    chk("rst_c3_rv", c3.rvalid, 0);
    nxt();
    rst_n = 1'b1;

    // contention: C, D, C, D
    cg = 0;
    dg = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_c", i), c1.gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_d", i), d1.gnt, (i % 2 == 1) ? 1 : 0);
      cg += int'(c1.gnt);
      dg += int'(d1.gnt);
      nxt();
    end
    chk("rr_c_cnt", cg, 2);
    chk("rr_d_cnt", dg, 2);
    c1.req = 1'b0;

    // preload 0x010 through D
    d1.addr = 10'h010; d1.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("pre_d_gnt", d1.gnt, 1);
    nxt();
    d1.req = 1'b0;

    // core-only read
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 10'h010;
    @(negedge clk);
    chk("rd_c_gnt", c1.gnt, 1);
    chk("rd_ram_addr", a1, 10'h010);
    chk("rd_ram_we", we1, 0);
    nxt();
    c1.req = 1'b0;
    @(negedge clk);
    chk("rd_c_rv", c1.rvalid, 1);
    chk("rd_c_data", c1.rdata, 32'hDEAD_BEEF);
    chk("rd_d_rv", d1.rvalid, 0);
    nxt();

    // C write then D read of the same word
    c1.req = 1'b1; c1.we = 1'b1; c1.addr = 10'h020;
    c1.wdata = 32'h1234_5678; c1.be = 4'hF;
    @(negedge clk);
    chk("mx_c_gnt", c1.gnt, 1);
    chk("mx_ram_we", we1, 1);
    chk("mx_ram_wd", wd1, 32'h1234_5678);
    nxt();
    c1.req = 1'b0;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 10'h020;
    @(negedge clk);
    chk("mx_d_gnt", d1.gnt, 1);
    chk("mx_c_rv0", c1.rvalid, 0);
    nxt();
    d1.req = 1'b0;
    @(negedge clk);
    chk("mx_d_rv", d1.rvalid, 1);
    chk("mx_d_data", d1.rdata, 32'h1234_5678);
    chk("mx_c_rv1", c1.rvalid, 0);
    chk("mx_c_hold", c1.rdata, 32'hDEAD_BEEF);
    nxt();

    // latency 3: preload, then C@1, D@2, C@3
    for (int i = 0; i < 3; i++) begin
      d3.req = 1'b1; d3.we = 1'b1;
      d3.addr = AW'(i + 1); d3.wdata = exp3[i];
      nxt();
    end
    d3.req = 1'b0;
    c3.we = 1'b0;
    d3.we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c3.req = (k == 0 || k == 2);
      d3.req = (k == 1);
      c3.addr = (k == 0) ? 10'h001 : 10'h003;
      d3.addr = 10'h002;
      @(negedge clk);
      if (k < 3)
        chk($sformatf("lat%0d_gnt", k), {c3.gnt, d3.gnt},
            (k == 1) ? 2'b01 : 2'b10);
      chk($sformatf("lat%0d_c_rv", k), c3.rvalid,
          (k == 3 || k == 5) ? 1 : 0);
      chk($sformatf("lat%0d_d_rv", k), d3.rvalid, (k == 4) ? 1 : 0);
      if (k >= 3)
        chk($sformatf("lat%0d_data", k),
            (k == 4) ? d3.rdata : c3.rdata, exp3[k-3]);
      nxt();
    end
    c3.req = 1'b0;
    d3.req = 1'b0;

    // reset while a C read is in flight
    c3.req = 1'b1; c3.we = 1'b0; c3.addr = 10'h001;
    @(negedge clk);
    chk("mr_c_gnt", c3.gnt, 1);
    nxt();
    c3.req = 1'b0;
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mr%0d_c_rv", k), c3.rvalid, 0);
      nxt();
    end
    c3.req = 1'b1; c3.we = 1'b1; c3.addr = 10'h3F0;
    d3.req = 1'b1; d3.we = 1'b1; d3.addr = 10'h3F1;
    @(negedge clk);
    chk("mr_rr_c", c3.gnt, 1);
    chk("mr_rr_d", d3.gnt, 0);
    nxt();
    c3.req = 1'b0;
    d3.req = 1'b0;

`ifdef RAM_ARB_LOCK_EN
    c1.req = 1'b1; c1.we = 1'b1; c1.addr = 10'h3F0;
    @(negedge clk);
    chk("lk_pre_c", c1.gnt, 1);
    nxt();
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 10'h3F1;
    lock1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lk%0d_d", k), d1.gnt, 1);
      chk($sformatf("lk%0d_c", k), c1.gnt, 0);
      nxt();
    end
    lock1 = 1'b0;
    d1.req = 1'b0;
    @(negedge clk);
    chk("lk_exit_c", c1.gnt, 0);
    nxt();
    @(negedge clk);
    chk("lk_open_c", c1.gnt, 1);
    nxt();
    c1.req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the core load/store path (port C, driven by the decoder's RAM read/write enables plus the ALU address) and the debug/program loader (port D).
- Arbitrates per cycle with round-robin fairness, issues one RAM command per cycle, and returns read data to the owning port after a fixed RAM read latency.
- Sits between the core datapath and the data RAM macro.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 10, RAM word-address width
- RD_LATENCY, 1, RAM read latency in cycles; legal range 1..4

Ports:
- clk_i  in  1  the single clock
- reset_ni  in  1  reset; synchronous, active-low
- c_req_i  in  1  core request, held until granted
- c_we_i  in  1  core write (1) / read (0)
- c_addr_i  in  ADDR_WIDTH  core word address
- c_wdata_i  in  DATA_WIDTH  core write data
- c_be_i  in  4  core byte enables
- c_gnt_o  out  1  core request accepted this cycle
- c_rvalid_o  out  1  core read data valid
- c_rdata_o  out  DATA_WIDTH  core read data
- d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i, d_gnt_o, d_rvalid_o, d_rdata_o  same as above, for the debug port
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_be_o  out  4  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after a read strobe

Behaviour:
- Reset (reset_ni=0 at a clk_i edge):
  - rr_ptr is set to C (core has priority).
  - Read-tag pipeline is cleared.
  - All rvalid outputs are 0.
  - gnt_o outputs and ram_en_o are forced to 0 while reset_ni=0.
- Grant logic (combinational from req inputs and registered state):
  - Only one requesting port: that port is granted.
  - Both ports requesting: the port not equal to rr_ptr... more precisely, rr_ptr names the preferred port, and the preferred port is granted.
  - No request: no grant, ram_en_o=0.
- Grant cycle:
  - ram_en_o=1 and ram_we_o/addr/wdata/be are muxed from the winner in the same cycle.
  - Exactly one gnt_o is 1.
- rr_ptr update on each clock edge with a grant: rr_ptr <= the other port. With no grant, rr_ptr holds.
- Handshake:
  - A requester keeps req and its attributes stable until gnt.
  - It may issue back-to-back requests every cycle.
  - There is no limit on outstanding reads.
- Read return:
  - The tag pipeline, RD_LATENCY deep, records {valid, owner} for each granted read.
  - At depth RD_LATENCY, the owner's rvalid_o=1 and its rdata_o=ram_rdata_i.
  - The other port's rvalid_o=0 and its rdata_o is held at its last value.
- Writes produce no rvalid.
- Simultaneous events: a read returning to C while D is granted is legal, and both happen in the same cycle.
- Read data is returned in issue order.
- Reset mid-read: pending tags are discarded and no rvalid is ever asserted for those reads.
- Throughput: 1 access per cycle. With both ports saturated, grants alternate C, D, C, D...

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- When defined:
  - Adds input d_lock_i (1 bit).
  - While port D holds a grant and d_lock_i=1, the FSM enters state LOCKED. In LOCKED, only D may be granted, C is starved, and rr_ptr is frozen.
  - On the first cycle with d_lock_i=0, the FSM returns to state OPEN and rr_ptr is set to C.
  - Reset forces OPEN.
  - Used for atomic multi-word program loads.
- When undefined: port absent, no lock FSM, pure round-robin.

Test Plan:
- Core-only read: c_req=1, c_we=0, c_addr=0x010, RAM word 0x010=0xDEADBEEF, RD_LATENCY=1 -> same-cycle c_gnt=1, ram_addr=0x010; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, d_rvalid=0.
- Contention: C and D both request for 4 cycles straight from reset -> grant order C, D, C, D; each port gets 2 grants.
- Mixed traffic: C write 0x12345678 to 0x020 with be=0xF, then D read of 0x020 the next cycle -> d_rvalid 1 cycle later with 0x12345678; no c_rvalid.
- Latency/order: RD_LATENCY=3 with reads C@0x1, D@0x2, C@0x3 in consecutive cycles -> rvalids on cycles 3, 4, 5 to C, D, C with the matching data.
- Reset mid-read: grant a C read, drive reset_ni=0 at the next edge, release -> c_rvalid stays 0 and rr_ptr=C.
- RAM_ARB_LOCK_EN: D granted with d_lock=1 for 3 cycles while C requests -> C gets no grant; d_lock=0 -> C granted on the next cycle.
